// File: rtl/aes_cmd_sequencer_if.sv
// Command/byte bus between the sequencer (master) and a byte-serial AES core (slave).
interface aes_cmd_sequencer_if #(
  parameter int CMD_WIDTH = 2
);
  logic [CMD_WIDTH-1:0] cmd;
  logic [7:0]           din;
  logic                 core_ready;
  logic                 core_ok;
  logic [7:0]           core_dout;

  modport master (output cmd, din, input core_ready, core_ok, core_dout);
  modport slave  (input cmd, din, output core_ready, core_ok, core_dout);
endinterface

// File: rtl/aes_cmd_sequencer.sv
// Sequences plaintext/key byte loads into an AES core, starts it, waits with a
// timeout and collects the 16-byte ciphertext.
module aes_cmd_sequencer #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int CMD_WIDTH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic                       key_reuse_i,
  input  logic [127:0]               pt_in_i,
  input  logic [127:0]               key_in_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [127:0]               ct_out_o,
  aes_cmd_sequencer_if.master        core
);

  typedef enum logic [3:0] {
    IDLE, LOAD_PT, GAP_PT, LOAD_K, GAP_K, STRT, WAIT, READ, DONE
  } state_e;

  localparam logic [CMD_WIDTH-1:0] CmdId = CMD_WIDTH'(0);
  localparam logic [CMD_WIDTH-1:0] CmdSt = CMD_WIDTH'(1);
  localparam logic [CMD_WIDTH-1:0] CmdSk = CMD_WIDTH'(2);
  localparam logic [CMD_WIDTH-1:0] CmdSp = CMD_WIDTH'(3);
  localparam logic [15:0]          TimeoutLast = 16'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [3:0]           byteCnt_q, byteCnt_d;
  logic [15:0]          timer_q, timer_d;
  logic [127:0]         pt_q, pt_d;
  logic [127:0]         key_q, key_d;
  logic [127:0]         ct_q, ct_d;
  logic                 reuse_q, reuse_d;
  logic                 keyValid_q, keyValid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [CMD_WIDTH-1:0] cmd_q, cmd_d;
  logic [7:0]           din_q, din_d;
  logic [6:0]           byteSel;

  always_comb begin
    state_d    = state_q;
    byteCnt_d  = byteCnt_q;
    timer_d    = timer_q;
    pt_d       = pt_q;
    key_d      = key_q;
    ct_d       = ct_q;
    reuse_d    = reuse_q;
    keyValid_d = keyValid_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && core.core_ready) begin
          state_d   = LOAD_PT;
          byteCnt_d = 4'd0;
          pt_d      = pt_in_i;
          key_d     = key_in_i;
          reuse_d   = key_reuse_i;
        end
      end
      LOAD_PT: begin
        byteCnt_d = byteCnt_q + 4'd1;
        if (byteCnt_q == 4'd15) state_d = GAP_PT;
      end
      GAP_PT: begin
        if (reuse_q && keyValid_q) begin
          state_d = STRT;
        end else begin
          state_d   = LOAD_K;
          byteCnt_d = 4'd0;
        end
      end
      LOAD_K: begin
        byteCnt_d = byteCnt_q + 4'd1;
        if (byteCnt_q == 4'd15) begin
          state_d    = GAP_K;
          keyValid_d = 1'b1;
        end
      end
      GAP_K: state_d = STRT;
      STRT: begin
        state_d = WAIT;
        timer_d = 16'd0;
      end
      // A timeout leaves the core state unknown, so the resident key is dropped.
      WAIT: begin
        if (core.core_ok) begin
          state_d   = READ;
          byteCnt_d = 4'd0;
        end else if (timer_q == TimeoutLast) begin
          state_d    = IDLE;
          err_d      = 1'b1;
          keyValid_d = 1'b0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      READ: begin
        ct_d[{byteCnt_q, 3'b000} +: 8] = core.core_dout;
        byteCnt_d = byteCnt_q + 4'd1;
        if (byteCnt_q == 4'd15) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state.
    byteSel = {byteCnt_d, 3'b000};
    cmd_d   = CmdId;
    din_d   = 8'd0;
    case (state_d)
      LOAD_PT: begin
        cmd_d = CmdSp;
        din_d = pt_d[byteSel +: 8];
      end
      LOAD_K: begin
        cmd_d = CmdSk;
        din_d = key_d[byteSel +: 8];
      end
      STRT:    cmd_d = CmdSt;
      default: ;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byteCnt_q  <= 4'd0;
      timer_q    <= 16'd0;
      pt_q       <= 128'd0;
      key_q      <= 128'd0;
      ct_q       <= 128'd0;
      reuse_q    <= 1'b0;
      keyValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cmd_q      <= CmdId;
      din_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      byteCnt_q  <= byteCnt_d;
      timer_q    <= timer_d;
      pt_q       <= pt_d;
      key_q      <= key_d;
      ct_q       <= ct_d;
      reuse_q    <= reuse_d;
      keyValid_q <= keyValid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cmd_q      <= cmd_d;
      din_q      <= din_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;
  assign ct_out_o = ct_q;
  assign core.cmd = cmd_q;
  assign core.din = din_q;

endmodule
